// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder that handles CHUNK bits per clock,
// carrying between chunks through a register, with a start/busy/done handshake.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Reject chunkings that do not tile the operand exactly
    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] partial;
    logic             c_reg;
    logic [IDXW-1:0]  idx;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] partial_next;
    logic             ovf_next;

    // Operands shift down one chunk per cycle, so the active chunk is always
    // the low CHUNK bits; the result fills partial from the top.
    always_comb begin
        csum         = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, c_reg};
        partial_next = (partial >> CHUNK)
                     | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        // On the last chunk the low chunk holds the original MSBs; the carry
        // into the MSB is recovered as a ^ b ^ s at that bit.
        ovf_next     = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
    end

    // Control FSM, chunk datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            idx      <= '0;
            c_reg    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            partial  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= b;
                        c_reg   <= cin;
                        idx     <= '0;
                        partial <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    op_a    <= op_a >> CHUNK;
                    op_b    <= op_b >> CHUNK;
                    partial <= partial_next;
                    c_reg   <= csum[CHUNK];
                    idx     <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        sum      <= partial_next;
                        carry    <= csum[CHUNK];
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: four configurations (16/4, 16/1, 16/16, 8/2) with a
// scoreboard of expected results compared when done pulses.
module tb_chunked_adder;

    typedef struct {
        int          d;
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    logic [3:0]       start_v;
    logic [3:0][15:0] a_v;
    logic [3:0][15:0] b_v;
    logic [3:0]       cin_v;
    logic [3:0]       busy_v;
    logic [3:0]       done_v;
    logic [3:0]       carry_v;
    logic [3:0]       ovf_v;
    logic [15:0]      sum0, sum1, sum2;
    logic [7:0]       sum3;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int w_t[4]   = '{16, 16, 16, 8};
    int nch_t[4] = '{4, 16, 1, 4};

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .carry(carry_v[0]), .overflow(ovf_v[0]));
    chunked_adder #(.WIDTH(16), .CHUNK(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .carry(carry_v[1]), .overflow(ovf_v[1]));
    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .carry(carry_v[2]), .overflow(ovf_v[2]));
    chunked_adder #(.WIDTH(8), .CHUNK(2)) u_d3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3][7:0]), .b(b_v[3][7:0]), .cin(cin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum3), .carry(carry_v[3]), .overflow(ovf_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sum_of(int d);
        case (d)
            0:       return sum0;
            1:       return sum1;
            2:       return sum2;
            default: return {8'h00, sum3};
        endcase
    endfunction

    // Reference: unsigned sum with carry, signed range check for overflow
    function automatic exp_t model(int d, logic [15:0] x, logic [15:0] y, logic ci);
        exp_t   r;
        int     w  = w_t[d];
        longint m  = (longint'(1) << w) - 1;
        longint ux = longint'(x) & m;
        longint uy = longint'(y) & m;
        longint s  = ux + uy + longint'(ci);
        longint sx = (ux > (m >> 1)) ? ux - (m + 1) : ux;
        longint sy = (uy > (m >> 1)) ? uy - (m + 1) : uy;
        longint ss = sx + sy + longint'(ci);
        r.d     = d;
        r.sum   = 16'(s & m);
        r.carry = ((s >> w) & 1) != 0;
        r.ovf   = (ss > (m >> 1)) || (ss < -((m + 1) >> 1));
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge: drive a request and queue its expected result
    task automatic launch(int d, logic [15:0] x, logic [15:0] y, logic ci);
        start_v[d] = 1'b1;
        a_v[d]     = x;
        b_v[d]     = y;
        cin_v[d]   = ci;
        sb.push_back(model(d, x, y, ci));
    endtask

    // Follow a launched request cycle by cycle; done must arrive exactly
    // NCHUNK edges after acceptance. Returns at the done negedge if chain=1.
    task automatic wait_done(int d, bit chain);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        chk("busy_after_start", 32'(busy_v[d]), 32'd1);
        chk("done_low_after_start", 32'(done_v[d]), 32'd0);
        for (int k = 1; k <= nch_t[d]; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < nch_t[d]) begin
                chk("busy_mid", 32'(busy_v[d]), 32'd1);
                chk("done_mid", 32'(done_v[d]), 32'd0);
            end else begin
                chk("done_at_latency", 32'(done_v[d]), 32'd1);
                chk("busy_at_done", 32'(busy_v[d]), 32'd0);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_dut", 32'(e.d), 32'(d));
                    chk("sum", 32'(sum_of(d)), 32'(e.sum));
                    chk("carry", 32'(carry_v[d]), 32'(e.carry));
                    chk("overflow", 32'(ovf_v[d]), 32'(e.ovf));
                end
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk("done_single_cycle", 32'(done_v[d]), 32'd0);
            chk("idle_after_done", 32'(busy_v[d]), 32'd0);
        end
    endtask

    task automatic run_one(int d, logic [15:0] x, logic [15:0] y, logic ci);
        @(negedge clk);
        launch(d, x, y, ci);
        wait_done(d, 1'b0);
    endtask

    initial begin
        exp_t tmp;
        rst     = 1'b1;
        start_v = '0;
        a_v     = '0;
        b_v     = '0;
        cin_v   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk("rst_busy", 32'(busy_v[d]), 32'd0);
            chk("rst_done", 32'(done_v[d]), 32'd0);
            chk("rst_sum", 32'(sum_of(d)), 32'd0);
            chk("rst_carry", 32'(carry_v[d]), 32'd0);
            chk("rst_ovf", 32'(ovf_v[d]), 32'd0);
        end

        // Directed cases on 16/4
        run_one(0, 16'h00FF, 16'h0001, 1'b0);
        run_one(0, 16'hFFFF, 16'h0001, 1'b0);
        run_one(0, 16'h7FFF, 16'h0000, 1'b1);
        run_one(0, 16'h1234, 16'h4321, 1'b1);

        // Start pulsed at E0+2 while busy is ignored
        @(negedge clk);
        launch(0, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        launch(0, 16'hAAAA, 16'h5555, 1'b1);
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        a_v[0]     = 16'h0F0F;
        @(posedge clk);
        @(negedge clk);
        chk("busy_ignored_start", 32'(busy_v[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("done_ignored_start", 32'(done_v[0]), 32'd1);
        tmp = sb.pop_front();
        chk("sum_ignored_start", 32'(sum0), 32'(tmp.sum));
        @(negedge clk);
        chk("no_extra_op_busy", 32'(busy_v[0]), 32'd0);
        chk("no_extra_op_done", 32'(done_v[0]), 32'd0);

        // Back-to-back: second start in the done cycle
        @(negedge clk);
        launch(0, 16'h1234, 16'h0001, 1'b0);
        wait_done(0, 1'b1);
        launch(0, 16'h8000, 16'h8000, 1'b0);
        wait_done(0, 1'b0);

        // Reset mid-operation discards the addition
        run_one(0, 16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        launch(0, 16'h00FF, 16'h0F01, 1'b1);
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        chk("midrst_sum", 32'(sum0), 32'd0);
        chk("midrst_carry", 32'(carry_v[0]), 32'd0);
        chk("midrst_ovf", 32'(ovf_v[0]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done_v[0]), 32'd0);
        end
        run_one(0, 16'hFFFF, 16'hFFFF, 1'b1);

        // Directed corners on the other configurations
        run_one(2, 16'h7FFF, 16'h0000, 1'b1);
        run_one(1, 16'hFFFF, 16'h0000, 1'b1);
        run_one(3, 16'h007F, 16'h0001, 1'b0);
        run_one(3, 16'h0080, 16'h0080, 1'b0);

        // Random sweep on every configuration, mixing idle and back-to-back
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            for (int n = 0; n < 200; n++) begin
                bit chain;
                chain = (n != 199) && ($urandom_range(0, 1) == 1);
                launch(d, 16'($urandom), 16'($urandom), 1'($urandom));
                wait_done(d, chain);
                if (!chain) @(negedge clk);
            end
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in by processing CHUNK bits per clock and rippling the carry between cycles through a register. It is the sequential, width-generic successor to the single-bit half adder and serves as the datapath adder wherever area matters more than latency. It uses a start/busy/done handshake and holds its result until the next completion.

## Interface
- WIDTH, 16, operand and sum width in bits; must be >= 1
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (elaboration error otherwise)
- NCHUNK, derived = WIDTH/CHUNK, cycles per addition (localparam)

- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous and active-high; one clock; reset is synchronous and active-high
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured at accepted start
- b  input  WIDTH  operand B, captured at accepted start
- cin  input  1  carry-in, captured at accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when result registers update
- sum  output  WIDTH  result, A+B+cin mod 2^WIDTH
- carry  output  1  unsigned carry-out of MSB
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- FSM states: IDLE, RUN. The done pulse is a registered flag, not a state.
- IDLE: busy=0. At an edge with start=1: latch a, b, and cin into internal op_a, op_b, and c_reg; idx<=0; go to RUN.
- RUN: busy=1. Each edge adds op_a[idx*CHUNK +: CHUNK] + op_b[same] + c_reg. The CHUNK-bit result goes into an internal partial register. c_reg takes the chunk carry-out. idx<=idx+1.
- On the last chunk (idx=NCHUNK-1), the same edge does the following:
  - sum<=full partial result including the final chunk.
  - carry<=final chunk carry-out.
  - overflow<=carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - done<=1, and the FSM returns to IDLE.
- sum, carry and overflow change only on the completion edge. They never show partial values and hold until the next completion.
- start while busy=1 is ignored; the captured operands stay unchanged. Input changes during RUN have no effect.
- start=1 in the cycle done=1 is accepted, since the FSM is already IDLE. Back-to-back additions therefore run with no idle gap.
- idx width is clog2(NCHUNK), minimum 1 bit. For the last chunk, idx is compared rather than wrapped.
- rst=1 at any edge, including mid-RUN:
  - The FSM goes to IDLE, and busy, done, sum, carry, overflow, idx and c_reg all go to 0.
  - Any in-flight addition is discarded, and no done pulse is issued for it.
- rst has priority over start.

## Timing
- Start accepted at edge E0: busy=1 from E0 through E0+NCHUNK-1; busy=0 after edge E0+NCHUNK.
- Result: valid, with done=1 for exactly one cycle, after edge E0+NCHUNK, giving latency NCHUNK clocks.
- Throughput: one addition per NCHUNK cycles with back-to-back start.
- CHUNK=WIDTH: NCHUNK=1, so the result arrives one clock after start and busy is high for one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: busy=0, done=0, sum=0, carry=0, overflow=0.

## Test plan
1. WIDTH=16, CHUNK=4: a=0x00FF, b=0x0001, cin=0. Expect done exactly 4 edges after start, with sum=0x0100, carry=0, overflow=0; busy is high for 4 cycles.
2. Full carry ripple, a=0xFFFF, b=0x0001, cin=0. Expect sum=0x0000, carry=1, overflow=0.
3. Signed overflow plus cin:
   - a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, carry=0, overflow=1.
   - a=0x1234, b=0x4321, cin=1 -> sum=0x5556.
4. Start while busy and back-to-back:
   - Pulse start with new operands at edge E0+2; expect it ignored and the result still for the first operands.
   - Assert start in the done cycle with 0x8000+0x8000; expect sum=0x0000, carry=1, overflow=1 four edges later.
5. Reset mid-op: assert rst for 1 cycle at E0+2. Expect busy=0, sum=0, carry=0 and overflow=0 next cycle, and no done pulse; a following start completes normally.
6. Sweep CHUNK in {1, 16} and WIDTH=8/CHUNK=2. Run 200 random operands against a+b+cin and check sum/carry/overflow, latency NCHUNK and a single-cycle done.
